uart_tx_arbiter: RTL

Shares one uart_tx transmitter between N_REQ byte-stream requesters using round-robin arbitration. A grant is held for a whole packet, delimited by req_last. Each packet can be framed with a header byte carrying the requester ID and a trailing XOR checksum byte. The block sits between the application-side producers and the uart_tx instance, driving its uart_tx_en and uart_tx_data and watching uart_tx_busy.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte-stream requesters.
// A grant lasts for a whole packet (ended by req_last). Each packet can be framed with a
// header byte {4'hA, id} and a trailing XOR checksum byte.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADD_HEADER = 1,
  parameter int unsigned ADD_CSUM   = 1,
  localparam int unsigned ID_W      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

  // Which byte of the packet is currently on the wire.
  typedef enum logic [1:0] {
    PhHdr,
    PhData,
    PhCsum
  } phase_e;

  state_e          state_q;
  phase_e          phase_q;
  logic [ID_W-1:0] ptr_q;
  logic            last_q;
  logic [7:0]      csum_q;

  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic [7:0]      hdr_byte;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;

  // Round-robin search: first valid requester after the last winner, wrapping modulo N_REQ.
  always_comb begin
    win_idx   = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = ID_W'((int'(ptr_q) + i) % int'(N_REQ));
      if (!win_found && req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Header for the requester about to be granted; ID zero-extended into the low nibble.
  always_comb begin
    hdr_byte = {4'hA, 4'(win_idx)};
  end

  // Per-requester signals of the current grant holder.
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_data  = req_data[{grant_id, 3'b000} +: 8];
    sel_last  = req_last[grant_id];
  end

  // Byte-accept strobe goes only to the grant holder, and only while waiting for a byte.
  always_comb begin
    req_ready = '0;
    if (state_q == StFetch && sel_valid) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // A packet is in progress whenever the controller is out of IDLE.
  always_comb begin
    active = (state_q != StIdle);
  end

  // Packet controller; tx_en is asserted on entry to SEND so it is high exactly in SEND.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      phase_q  <= PhHdr;
      ptr_q    <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      last_q   <= 1'b0;
      csum_q   <= 8'h00;
    end else begin
      tx_en <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!tx_busy && (|req_valid)) begin
            grant_id <= win_idx;
            ptr_q    <= win_idx;
            if (ADD_HEADER != 0) begin
              tx_data <= hdr_byte;
              csum_q  <= hdr_byte;
              phase_q <= PhHdr;
              tx_en   <= 1'b1;
              state_q <= StSend;
            end else begin
              csum_q  <= 8'h00;
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            last_q  <= sel_last;
            csum_q  <= csum_q ^ sel_data;
            phase_q <= PhData;
            tx_en   <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (tx_busy) begin
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!tx_busy) begin
            case (phase_q)
              PhHdr: state_q <= StFetch;
              PhData: begin
                if (!last_q) begin
                  state_q <= StFetch;
                end else if (ADD_CSUM != 0) begin
                  tx_data <= csum_q;
                  phase_q <= PhCsum;
                  tx_en   <= 1'b1;
                  state_q <= StSend;
                end else begin
                  state_q <= StIdle;
                end
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
